vid_out_pipe: RTL

VID_OUT_PIPE -- requirements
Module: vid_out_pipe

---
 rtl/vid_pkg.sv | 12 +
 rtl/vid_ce_div.sv | 33 +++
 rtl/vid_out_pipe.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vid_pkg.sv
// Shared constants for the video output pipeline: line counter width and
// legal ranges of the pipeline parameters.
package vid_pkg;
   localparam int LINE_CNT_W     = 10;
   localparam int CE_DIV_MIN     = 2;
   localparam int CE_DIV_MAX     = 16;
   localparam int COLOR_W_MIN    = 4;
   localparam int COLOR_W_MAX    = 10;
   localparam int PIPE_DEPTH_MIN = 1;
   localparam int PIPE_DEPTH_MAX = 8;
   localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX = '1;
endpackage

// File: rtl/vid_ce_div.sv
// Pixel clock-enable divider: counts 0..CE_DIV-1 and emits a registered
// single-cycle enable when the count reaches its last value.
module vid_ce_div
   import vid_pkg::*;
#(
   parameter int CE_DIV = 2
)(
   input  logic clk_vid,
   input  logic reset,
   output logic o_ce
);
   localparam int CNT_W = $clog2(CE_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CE_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_ce;

   if (CE_DIV < CE_DIV_MIN || CE_DIV > CE_DIV_MAX) begin : g_bad_ce_div
      $error("vid_ce_div: CE_DIV out of range");
   end

   always_ff @(posedge clk_vid) begin
      if (reset) begin
         r_cnt <= '0;
         r_ce  <= 1'b0;
      end else begin
         r_ce  <= (r_cnt == CNT_LAST);
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_ce = r_ce;
endmodule

// File: rtl/vid_out_pipe.sv
// Video output pipeline: clock-enabled delay line for colour/sync/de with
// blanking, an active-line counter, and optional scanline dimming
// compiled in with VID_OUT_SCANLINE_EN.
module vid_out_pipe
   import vid_pkg::*;
#(
   parameter int CE_DIV     = 2,
   parameter int COLOR_W    = 8,
   parameter int PIPE_DEPTH = 2
)(
   input  logic                  clk_vid,
   input  logic                  reset,
   input  logic [COLOR_W-1:0]    r_in,
   input  logic [COLOR_W-1:0]    g_in,
   input  logic [COLOR_W-1:0]    b_in,
   input  logic                  hblank_in,
   input  logic                  vblank_in,
   input  logic                  hs_in,
   input  logic                  vs_in,
   input  logic                  scanline_en,
   output logic                  ce_pix,
   output logic [COLOR_W-1:0]    r,
   output logic [COLOR_W-1:0]    g,
   output logic [COLOR_W-1:0]    b,
   output logic                  hs,
   output logic                  vs,
   output logic                  de,
   output logic [LINE_CNT_W-1:0] line_cnt
);
   localparam int LAST = PIPE_DEPTH - 1;
   localparam int NCH  = 3;

   logic                  w_ce;
   logic [COLOR_W-1:0]    w_in  [NCH];
   logic [COLOR_W-1:0]    w_out [NCH];
   logic [COLOR_W-1:0]    r_col [PIPE_DEPTH][NCH];
   logic [PIPE_DEPTH-1:0] r_hs, r_vs, r_de;
   logic                  r_hb_prev, r_vb_prev, r_hist_vld;
   logic                  w_hb_rise, w_vb_rise;
   logic [LINE_CNT_W-1:0] r_line_cnt, w_line_next;

   if (COLOR_W < COLOR_W_MIN || COLOR_W > COLOR_W_MAX) begin : g_bad_color_w
      $error("vid_out_pipe: COLOR_W out of range");
   end
   if (PIPE_DEPTH < PIPE_DEPTH_MIN || PIPE_DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
      $error("vid_out_pipe: PIPE_DEPTH out of range");
   end

   vid_ce_div #(.CE_DIV(CE_DIV)) u_ce_div (
      .clk_vid (clk_vid),
      .reset   (reset),
      .o_ce    (w_ce)
   );

   assign w_in[0] = r_in;
   assign w_in[1] = g_in;
   assign w_in[2] = b_in;

   always_ff @(posedge clk_vid) begin
      if (reset) begin
         for (int i = 0; i < PIPE_DEPTH; i++)
            for (int c = 0; c < NCH; c++)
               r_col[i][c] <= '0;
         r_hs <= '0;
         r_vs <= '0;
         r_de <= '0;
      end else if (w_ce) begin
         for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
            for (int c = 0; c < NCH; c++)
               r_col[i][c] <= r_col[i-1][c];
            r_hs[i] <= r_hs[i-1];
            r_vs[i] <= r_vs[i-1];
            r_de[i] <= r_de[i-1];
         end
         for (int c = 0; c < NCH; c++)
            r_col[0][c] <= w_in[c];
         r_hs[0] <= hs_in;
         r_vs[0] <= vs_in;
         r_de[0] <= ~(hblank_in | vblank_in);
      end
   end

   // History is only trusted after the first sample, so it never fakes an edge.
   always_comb begin
      w_hb_rise   = r_hist_vld & hblank_in & ~r_hb_prev;
      w_vb_rise   = r_hist_vld & vblank_in & ~r_vb_prev;
      w_line_next = r_line_cnt;
      if (w_vb_rise)
         w_line_next = '0;
      else if (w_hb_rise && !vblank_in && r_line_cnt != LINE_CNT_MAX)
         w_line_next = r_line_cnt + 1'b1;
   end

   always_ff @(posedge clk_vid) begin
      if (reset) begin
         r_line_cnt <= '0;
         r_hb_prev  <= 1'b0;
         r_vb_prev  <= 1'b0;
         r_hist_vld <= 1'b0;
      end else if (w_ce) begin
         r_line_cnt <= w_line_next;
         r_hb_prev  <= hblank_in;
         r_vb_prev  <= vblank_in;
         r_hist_vld <= 1'b1;
      end
   end

`ifdef VID_OUT_SCANLINE_EN
   // Line parity travels with each pixel so dimming matches the emitted line.
   logic [PIPE_DEPTH-1:0] r_lsb;
   logic                  w_dim;

   always_ff @(posedge clk_vid) begin
      if (reset) begin
         r_lsb <= '0;
      end else if (w_ce) begin
         for (int i = PIPE_DEPTH - 1; i > 0; i--)
            r_lsb[i] <= r_lsb[i-1];
         r_lsb[0] <= w_line_next[0];
      end
   end

   assign w_dim = scanline_en & r_lsb[LAST];
`else
   logic w_unused_scanline;
   assign w_unused_scanline = scanline_en;
`endif

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      logic [COLOR_W-1:0] w_blanked;
      assign w_blanked = r_de[LAST] ? r_col[LAST][gi] : '0;
`ifdef VID_OUT_SCANLINE_EN
      assign w_out[gi] = w_dim ? (w_blanked >> 1) : w_blanked;
`else
      assign w_out[gi] = w_blanked;
`endif
   end

   assign ce_pix   = w_ce;
   assign r        = w_out[0];
   assign g        = w_out[1];
   assign b        = w_out[2];
   assign hs       = r_hs[LAST];
   assign vs       = r_vs[LAST];
   assign de       = r_de[LAST];
   assign line_cnt = r_line_cnt;
endmodule
